// File: rtl/ulaplus_video_pkg.sv
// Shared types and helpers for the ULAplus video path.
// Palette entries are GGGRRRBB and get expanded to 3 bits per channel.
package ulaplus_video_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb9_t;

    // Palette index layout: [5:4] CLUT, [3] paper select, [2:0] colour
    localparam int unsigned ULAPLUS_PAPER_BIT  = 3;
    localparam int unsigned ULAPLUS_CLUT_SHIFT = 4;

    // Blue has only two bits; the LSB is synthesised as their OR.
    // Result: 00->000, 01->011, 10->101, 11->111.
    function automatic rgb9_t ulaplus_expand(input logic [7:0] entry);
        rgb9_t c;
        c.g = entry[7:5];
        c.r = entry[4:2];
        c.b = {entry[1], entry[0], entry[1] | entry[0]};
        return c;
    endfunction

endpackage

// File: rtl/ulaplus_video.sv
// ULAplus video consumer: attribute/border -> palette indices -> RGB.
// Two-stage pipeline on ce_pix; standard colour bypass keeps the same latency.
module ulaplus_video
    import ulaplus_video_pkg::*;
#(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       active,
    input  logic       ce_pix,
    input  logic       pix,
    input  logic [7:0] attr,
    input  logic       border,
    input  logic [2:0] border_color,
    input  logic       blank,
    input  logic [8:0] ula_rgb,
    output logic [5:0] read_addr1,
    output logic [5:0] read_addr2,
    input  logic [7:0] read_data1,
    input  logic [7:0] read_data2,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [2:0] b
);

    if ((PIX_DIV < 4) || ((PIX_DIV % 2) != 0)) begin : g_bad_pix_div
        $error("ulaplus_video: PIX_DIV must be even and >= 4");
    end

    logic [5:0] ink_idx;
    logic [5:0] paper_idx;
    logic       sel;
    logic       blank_d;
    logic       active_d;
    logic [8:0] ula_rgb_d;
    rgb9_t      pal_rgb;
    rgb9_t      rgb_q;
    rgb9_t      rgb_nxt;

    always_comb begin
        ink_idx   = '0;
        paper_idx = '0;
        if (border) begin
            // Border uses the paper half of CLUT 0
            ink_idx[ULAPLUS_PAPER_BIT] = 1'b1;
            ink_idx[2:0]               = border_color;
            paper_idx                  = ink_idx;
        end else begin
            ink_idx[ULAPLUS_CLUT_SHIFT +: 2]   = attr[7:6];
            ink_idx[2:0]                       = attr[2:0];
            paper_idx[ULAPLUS_CLUT_SHIFT +: 2] = attr[7:6];
            paper_idx[ULAPLUS_PAPER_BIT]       = 1'b1;
            paper_idx[2:0]                     = attr[5:3];
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            read_addr1 <= '0;
            read_addr2 <= '0;
            sel        <= 1'b0;
            blank_d    <= 1'b0;
            active_d   <= 1'b0;
            ula_rgb_d  <= '0;
        end else if (ce_pix) begin
            read_addr1 <= ink_idx;
            read_addr2 <= paper_idx;
            sel        <= pix & ~border;
            blank_d    <= blank;
            active_d   <= active;
            ula_rgb_d  <= ula_rgb;
        end
    end

    always_comb begin
        pal_rgb = ulaplus_expand(sel ? read_data1 : read_data2);
        rgb_nxt = active_d ? pal_rgb : rgb9_t'(ula_rgb_d);
        if (blank_d) begin
            rgb_nxt = '0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else if (ce_pix) begin
            rgb_q <= rgb_nxt;
        end
    end

    assign r = rgb_q.r;
    assign g = rgb_q.g;
    assign b = rgb_q.b;

endmodule

// File: tb/tb_ulaplus_video.sv
// Directed bench for ulaplus_video with a simple 2-clk-latency palette model
// whose slot refresh can be stolen for one clock to mimic a CPU access.
module tb_ulaplus_video;

    localparam int unsigned PIX_DIV = 4;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       active;
    logic       ce_pix;
    logic       pix;
    logic [7:0] attr;
    logic       border;
    logic [2:0] border_color;
    logic       blank;
    logic [8:0] ula_rgb;
    logic [5:0] read_addr1;
    logic [5:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;

    logic [7:0] pal [64];
    logic [7:0] p1;
    logic [7:0] p2;
    logic       steal = 1'b0;
    logic       ce_en = 1'b0;
    int unsigned ce_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk28 = ~clk28;

    ulaplus_video #(.PIX_DIV(PIX_DIV)) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .active      (active),
        .ce_pix      (ce_pix),
        .pix         (pix),
        .attr        (attr),
        .border      (border),
        .border_color(border_color),
        .blank       (blank),
        .ula_rgb     (ula_rgb),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    // Palette model: address sampled, then data appears one clock later
    always @(posedge clk28) begin
        if (!steal) begin
            p1 <= pal[read_addr1];
            p2 <= pal[read_addr2];
        end
        read_data1 <= p1;
        read_data2 <= p2;
    end

    initial begin
        ce_pix = 1'b0;
        forever begin
            @(negedge clk28);
            if (ce_en) begin
                ce_pix = (ce_cnt == 0);
                ce_cnt = (ce_cnt + 1) % PIX_DIV;
            end else begin
                ce_pix = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next ce_pix edge, bounded
    task automatic step();
        int n = 0;
        do begin
            @(posedge clk28);
            n++;
        end while (!ce_pix && n < 4 * PIX_DIV);
        if (!ce_pix) check("ce_timeout", 9'd1, 9'd0);
        #1;
    endtask

    function automatic logic [8:0] rgb();
        return {r, g, b};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) pal[i] = 8'h00;
        pal[53] = 8'hE3;
        pal[56] = 8'h1C;
        pal[10] = 8'h49;
        rst_n = 1'b0;
        active = 1'b0; pix = 1'b0; attr = 8'h00; border = 1'b0;
        border_color = 3'd0; blank = 1'b0; ula_rgb = '0;
        ce_en = 1'b1;

        #1;
        check("reset_rgb", rgb(), 9'd0);
        check("reset_addr1", {3'd0, read_addr1}, 9'd0);
        check("reset_addr2", {3'd0, read_addr2}, 9'd0);
        repeat (3) @(posedge clk28);
        #2 rst_n = 1'b1;

        // Paper area, ink pixel
        active = 1'b1; attr = 8'hC5; pix = 1'b1;
        step();
        check("ink_addr1", {3'd0, read_addr1}, 9'd53);
        check("ink_addr2", {3'd0, read_addr2}, 9'd56);

        // Paper pixel, same attr
        pix = 1'b0;
        step();
        check("ink_rgb", rgb(), {3'd0, 3'd7, 3'd7});
        check("paper_addr1", {3'd0, read_addr1}, 9'd53);

        // Border
        border = 1'b1; border_color = 3'd2;
        step();
        check("paper_rgb", rgb(), {3'd7, 3'd0, 3'd0});
        check("border_addr1", {3'd0, read_addr1}, 9'd10);
        check("border_addr2", {3'd0, read_addr2}, 9'd10);

        // Standard mode bypass; addresses still follow attr 0x12
        border = 1'b0; active = 1'b0; ula_rgb = 9'b101_010_110; attr = 8'h12;
        step();
        check("border_rgb", rgb(), {3'd2, 3'd2, 3'd3});
        check("std_addr1", {3'd0, read_addr1}, 9'd2);
        check("std_addr2", {3'd0, read_addr2}, 9'd10);
        repeat (PIX_DIV - 1) @(posedge clk28);
        #1;
        check("hold_mid_pixel", rgb(), {3'd2, 3'd2, 3'd3});

        // Blank in ULAplus mode
        active = 1'b1; blank = 1'b1; attr = 8'hC5; pix = 1'b1;
        step();
        check("std_rgb", rgb(), 9'b101_010_110);

        // Blank in standard mode
        active = 1'b0; blank = 1'b1; ula_rgb = 9'h1FF;
        step();
        check("blank_active", rgb(), 9'd0);

        active = 1'b1; blank = 1'b0; attr = 8'hC5; pix = 1'b1;
        step();
        check("blank_std", rgb(), 9'd0);

        // CPU write to entry 53 late in the pixel, stealing one read slot
        repeat (2) @(posedge clk28);
        #1;
        steal = 1'b1;
        pal[53] = 8'h03;
        @(posedge clk28);
        #1;
        steal = 1'b0;
        step();
        check("pre_write", rgb(), {3'd0, 3'd7, 3'd7});
        step();
        check("post_write", rgb(), {3'd0, 3'd0, 3'd7});

        // ce_pix held low: everything freezes
        ce_en = 1'b0;
        attr = 8'h00; pix = 1'b0; active = 1'b0; ula_rgb = 9'h1FF;
        repeat (3 * PIX_DIV) @(posedge clk28);
        #1;
        check("freeze_rgb", rgb(), {3'd0, 3'd0, 3'd7});
        check("freeze_addr1", {3'd0, read_addr1}, 9'd53);
        check("freeze_addr2", {3'd0, read_addr2}, 9'd56);
        ce_en = 1'b1;

        // Asynchronous reset mid-line
        active = 1'b1; attr = 8'hC5; pix = 1'b1;
        step();
        @(posedge clk28);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb(), 9'd0);
        check("async_rst_addr1", {3'd0, read_addr1}, 9'd0);
        check("async_rst_addr2", {3'd0, read_addr2}, 9'd0);
        @(posedge clk28);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_first", rgb(), 9'd0);
        check("post_rst_addr1", {3'd0, read_addr1}, 9'd53);
        step();
        check("post_rst_valid", rgb(), {3'd0, 3'd0, 3'd7});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ulaplus_video.md
Name: ulaplus_video

Overview:
- Video-side consumer of the ULAplus palette.
- On each pixel strobe it turns the ULA attribute byte, pixel bit and border state into two 6-bit palette indices: ink on port 1, paper on port 2.
- It drives those indices onto the palette's time-multiplexed read ports and expands the returned GGGRRRBB entries to 3-bit-per-channel RGB.
- Sits between the screen/border generator and the video output mux. When ULAplus is inactive it passes the standard ULA colour through with identical latency.

Parameters:
- PIX_DIV, 4: clk28 cycles per pixel strobe. Must be even and >= 4 so that at least two palette read slot pairs fit in one pixel.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- active  in  1  ULAplus mode enable, from palette block
- ce_pix  in  1  one-clk28 strobe per pixel, every PIX_DIV cycles
- pix  in  1  current pixel bit (1 = ink)
- attr  in  8  attribute byte: [7:6] CLUT, [5:3] paper, [2:0] ink
- border  in  1  current pixel is border
- border_color  in  3  border colour, port FE bits [2:0]
- blank  in  1  horizontal/vertical blanking
- ula_rgb  in  9  standard-mode colour {r[2:0], g[2:0], b[2:0]}
- read_addr1  out  6  palette index, ink/border slot
- read_addr2  out  6  palette index, paper slot
- read_data1  in  8  palette entry for read_addr1, GGGRRRBB
- read_data2  in  8  palette entry for read_addr2, GGGRRRBB
- r  out  3  red
- g  out  3  green
- b  out  3  blue

Behaviour:
- Reset: read_addr1 = read_addr2 = 0; r = g = b = 0; all pipeline registers cleared, including the stage-1 registers sel, blank_d and ula_rgb_d.
- Index calculation, registered on ce_pix (stage 1):
  - Paper area: read_addr1 = {attr[7:6], 1'b0, attr[2:0]}; read_addr2 = {attr[7:6], 1'b1, attr[5:3]}.
  - Border: both addresses = {2'b00, 1'b1, border_color}.
  - Also latched on ce_pix: sel = pix & ~border, blank_d = blank, active_d = active, ula_rgb_d = ula_rgb.
- Addresses are held constant for the whole pixel period. The palette alternates ports every clk28 with a 2-clk read latency, so read_data1/2 are settled no later than PIX_DIV-1 clocks after the address change. This holds even if one CPU palette access steals one slot in that pixel.
- Stage 2, on the next ce_pix:
  - entry = sel ? read_data1 : read_data2.
  - g = entry[7:5], r = entry[4:2], b = {entry[1], entry[0], entry[1]|entry[0]}.
  - Blue expansion: 00 -> 000, 01 -> 011, 10 -> 101, 11 -> 111.
  - If active_d = 0: {r,g,b} = ula_rgb_d.
  - If blank_d = 1: {r,g,b} = 0, overriding both paths.
- Latency: input sampled at ce_pix N appears on r/g/b at ce_pix N+1 (PIX_DIV clocks) for both paths. Outputs change only on ce_pix.
- FLASH is not applied in ULAplus mode, since attr[7] is a CLUT bit. Flash in standard mode is already resolved upstream in ula_rgb.
- Mode change: active sampled per pixel. A toggle mid-line switches cleanly at the pixel boundary, with no mixed output.
- ce_pix held low: outputs and addresses freeze.
- Reset asserted mid-frame: outputs go to 0 immediately (async). The first valid pixel appears one pixel period after reset release.

Decomposition:
- common package:
  - typedef rgb9_t (packed r, g, b, 3 bits each).
  - constants ULAPLUS_PAPER_BIT = 3 and ULAPLUS_CLUT_SHIFT = 4.
  - function ulaplus_expand(input [7:0] entry) returning rgb9_t.
- No sub-module: index stage and expand stage stay inline.

Test Plan:
- active=1, palette[53]=0xE3, palette[56]=0x1C, attr=0xC5, pix=1, border=0 -> read_addr1=53, read_addr2=56; next pixel r=0, g=7, b=7.
- Same attr, pix=0 -> r=7, g=0, b=0, from palette[56]=0x1C.
- border=1, border_color=2, palette[10]=0x49 -> both addresses 10; r=2, g=2, b=3 (01 -> 011).
- active=0, ula_rgb=9'b101_010_110, blank=0 -> r=5, g=2, b=6 exactly PIX_DIV clocks after the sampling ce_pix; addresses still track attr.
- blank=1 with any input, either mode -> r=g=b=0 on the next pixel.
- CPU writes palette[53]=0x03 during the pixel sampling index 53 (one stolen slot) -> that pixel outputs the pre-write entry; next pixel using 53 outputs b=7, r=g=0. Also: rst_n pulsed low mid-line -> r/g/b/addresses 0 asynchronously; first valid pixel one pixel period after release.
